// File: rtl/neopix_bank_scheduler_if.sv
// Writer/reader handshake bundle for the neopixel double-buffer bank scheduler.
// master = SPI writer + ws2812 reader side, slave = scheduler.
interface neopix_bank_scheduler_if #(
    parameter int CW = 4
) ();
    logic          WR_START;
    logic          WR_LED;
    logic          WR_END;
    logic          WR_BANK;
    logic          RD_RESET_STATE;
    logic          RD_BANK;
    logic [CW-1:0] RD_COUNT;
    logic          FRAME_SWAP;
    logic          DROPPED;

    modport master (
        output WR_START, WR_LED, WR_END, RD_RESET_STATE,
        input  WR_BANK, RD_BANK, RD_COUNT, FRAME_SWAP, DROPPED
    );

    modport slave (
        input  WR_START, WR_LED, WR_END, RD_RESET_STATE,
        output WR_BANK, RD_BANK, RD_COUNT, FRAME_SWAP, DROPPED
    );
endinterface

// File: rtl/neopix_bank_scheduler.sv
// Double-buffer bank scheduler between the SPI frame writer and the ws2812 serialiser.
// Optional idle blanking of the strip is enabled by defining NEOPIX_BLANK_EN.
module neopix_bank_scheduler #(
    parameter int NUM_LEDS         = 8,
    parameter int MIN_FRAME_CYCLES = 50000,
    parameter int BLANK_TIMEOUT    = 50000000,
    localparam int CW              = $clog2(NUM_LEDS) + 1,
    localparam int TW              = $clog2(MIN_FRAME_CYCLES + 1)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    neopix_bank_scheduler_if.slave      bus
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FILL  = 2'd1;
    localparam logic [1:0] W_READY = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] wr_count_r;
    logic [CW-1:0] wr_count_nxt_s;
    logic [TW-1:0] timer_r;
    logic          timer_exp_s;
    logic          rd_bank_r;
    logic [CW-1:0] rd_count_r;
    logic          frame_swap_r;
    logic          dropped_r;
    logic          swap_s;
    logic          drop_s;
    logic          blank_s;

    assign timer_exp_s = (timer_r == TW'(MIN_FRAME_CYCLES));
    // A WR_START in the same cycle wins over the swap: the pending frame is being replaced.
    assign swap_s      = (state_r == W_READY) && bus.RD_RESET_STATE && timer_exp_s && !bus.WR_START;
    assign drop_s      = (state_r == W_READY) && bus.WR_START;

    // Writer FSM next-state and LED count
    always_comb begin
        state_nxt_s    = state_r;
        wr_count_nxt_s = wr_count_r;
        case (state_r)
            W_IDLE: begin
                if (bus.WR_START) begin
                    state_nxt_s    = W_FILL;
                    wr_count_nxt_s = {CW{1'b0}};
                end else begin
                    state_nxt_s    = W_IDLE;
                end
            end
            W_FILL: begin
                if (bus.WR_START) begin
                    wr_count_nxt_s = {CW{1'b0}};
                end else begin
                    if (bus.WR_LED && (wr_count_r < CW'(NUM_LEDS))) begin
                        wr_count_nxt_s = wr_count_r + CW'(1);
                    end else begin
                        wr_count_nxt_s = wr_count_r;
                    end
                    if (bus.WR_END) begin
                        state_nxt_s = W_READY;
                    end else begin
                        state_nxt_s = W_FILL;
                    end
                end
            end
            W_READY: begin
                if (bus.WR_START) begin
                    state_nxt_s    = W_FILL;
                    wr_count_nxt_s = {CW{1'b0}};
                end else if (swap_s) begin
                    state_nxt_s    = W_IDLE;
                end else begin
                    state_nxt_s    = W_READY;
                end
            end
            default: begin
                state_nxt_s    = W_IDLE;
                wr_count_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // Writer FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= W_IDLE;
            wr_count_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wr_count_r <= wr_count_nxt_s;
        end
    end

    // Minimum frame interval timer; starts expired so the first frame is not held back
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer_r <= TW'(MIN_FRAME_CYCLES);
        end else if (swap_s) begin
            timer_r <= {TW{1'b0}};
        end else if (!timer_exp_s) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

`ifdef NEOPIX_BLANK_EN
    localparam int IW = $clog2(BLANK_TIMEOUT + 1);

    logic [IW-1:0] idle_r;
    logic          idle_done_s;

    assign idle_done_s = (idle_r == IW'(BLANK_TIMEOUT));
    assign blank_s     = idle_done_s && bus.RD_RESET_STATE && !swap_s;

    // Idle counter since the last swap, saturating once the blank timeout is reached
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idle_r <= {IW{1'b0}};
        end else if (swap_s) begin
            idle_r <= {IW{1'b0}};
        end else if (!idle_done_s) begin
            idle_r <= idle_r + IW'(1);
        end else begin
            idle_r <= idle_r;
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    // Reader bank select and LED count; only change on a swap (or an idle blank)
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_bank_r  <= 1'b1;
            rd_count_r <= {CW{1'b0}};
        end else if (swap_s) begin
            rd_bank_r  <= ~rd_bank_r;
            rd_count_r <= wr_count_r;
        end else if (blank_s) begin
            rd_count_r <= {CW{1'b0}};
        end else begin
            rd_bank_r  <= rd_bank_r;
            rd_count_r <= rd_count_r;
        end
    end

    // Single-cycle event pulses
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frame_swap_r <= 1'b0;
            dropped_r    <= 1'b0;
        end else begin
            frame_swap_r <= swap_s;
            dropped_r    <= drop_s;
        end
    end

    assign bus.RD_BANK    = rd_bank_r;
    assign bus.WR_BANK    = ~rd_bank_r;
    assign bus.RD_COUNT   = rd_count_r;
    assign bus.FRAME_SWAP = frame_swap_r;
    assign bus.DROPPED    = dropped_r;

endmodule

// File: doc/neopix_bank_scheduler.md
Name: neopix_bank_scheduler

Overview:
- Double-buffer bank scheduler between the SPI frame writer and the ws2812 serialiser.
- Owns the bank-select bit for both sides and the per-bank LED count.
- Hands a completed SPI frame to the reader only inside a ws2812 reset/latch period, and no faster than a programmable minimum frame interval.
- Drops (overwrites) a pending frame if a newer one arrives before the swap.

Parameters:
- NUM_LEDS, 8: LEDs per bank; count width CW = $clog2(NUM_LEDS)+1.
- MIN_FRAME_CYCLES, 50000: minimum CLK cycles between bank swaps (1 ms at 50 MHz); must be >= 1.
- BLANK_TIMEOUT, 50000000: idle cycles before blanking; used only with NEOPIX_BLANK_EN.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- WR_START  in  1  1-cycle pulse: SPI frame begins (SSEL falling, synchronised).
- WR_LED  in  1  1-cycle pulse: one 24-bit LED word written to RAM.
- WR_END  in  1  1-cycle pulse: SPI frame ends (SSEL rising, synchronised).
- WR_BANK  out  1  bank the writer targets; always equals ~RD_BANK.
- RD_RESET_STATE  in  1  ws2812 is in its reset/latch period.
- RD_BANK  out  1  bank the ws2812 reads.
- RD_COUNT  out  CW  valid LEDs in RD_BANK; LEDs at or above this index are sent black.
- FRAME_SWAP  out  1  1-cycle pulse on the cycle RD_BANK toggles.
- DROPPED  out  1  1-cycle pulse when a pending frame is overwritten.

Behaviour:
- Reset (RESET=0, async):
  - RD_BANK=1, WR_BANK=0, RD_COUNT=0, FRAME_SWAP=0, DROPPED=0.
  - State W_IDLE, wr_count=0.
  - Interval timer preset to MIN_FRAME_CYCLES (expired), so the first frame swaps without waiting.
- Writer FSM, states W_IDLE, W_FILL, W_READY:
  - W_IDLE: on WR_START, clear wr_count and go to W_FILL. WR_LED and WR_END are ignored.
  - W_FILL: WR_LED increments wr_count, saturating at NUM_LEDS. WR_START clears wr_count and stays in W_FILL (restart, not a drop). On WR_END go to W_READY. If WR_LED and WR_END occur in the same cycle, the LED is counted first. WR_END with wr_count=0 is a legal empty frame (blanks the strip).
  - W_READY: a frame is pending in WR_BANK. WR_START clears wr_count, goes to W_FILL and pulses DROPPED; no swap that cycle. WR_LED and WR_END are ignored.
- Swap condition: state==W_READY, RD_RESET_STATE==1, timer expired, and no WR_START this cycle.
  - On the next edge RD_BANK and WR_BANK toggle, RD_COUNT<=wr_count, FRAME_SWAP pulses, timer clears, state goes to W_IDLE.
  - A swap is valid anywhere within the reset period; RD_BANK and RD_COUNT are stable outside swaps.
- Timer: counts CLK cycles and saturates at MIN_FRAME_CYCLES; expired when equal to MIN_FRAME_CYCLES. Width $clog2(MIN_FRAME_CYCLES+1).
- Registered outputs; latency is 1 cycle from the qualifying condition to the output change.
- Reset asserted mid-frame: all state returns to reset values, the pending frame is lost, and no pulses are issued.
- Invariant: WR_BANK==~RD_BANK at all times.

Optional Feature:
- NEOPIX_BLANK_EN defined:
  - An idle counter runs and clears on every FRAME_SWAP.
  - When it reaches BLANK_TIMEOUT, the next cycle with RD_RESET_STATE=1 sets RD_COUNT<=0 with no bank toggle and no FRAME_SWAP pulse.
  - The counter then saturates until the next swap.
- Undefined: no idle counter; RD_COUNT holds indefinitely.

Test Plan (MIN_FRAME_CYCLES=100, NUM_LEDS=8, BLANK_TIMEOUT=500):
- Release reset; WR_START, 5×WR_LED, WR_END, RD_RESET_STATE=1 -> one cycle later FRAME_SWAP=1, RD_BANK=0, WR_BANK=1, RD_COUNT=5.
- Frame completes 20 cycles after a swap with RD_RESET_STATE held 1 -> swap delayed until 100 cycles after the previous swap; exactly one FRAME_SWAP.
- Frame A (3 LEDs) pending, RD_RESET_STATE=0, then frame B (7 LEDs) -> DROPPED pulses once at B's WR_START; next swap gives RD_COUNT=7.
- 12×WR_LED in one frame -> RD_COUNT=8 (saturated); empty frame (WR_START, WR_END) -> RD_COUNT=0 after swap.
- RESET low mid-W_FILL with 4 LEDs counted -> RD_BANK=1, RD_COUNT=0, no FRAME_SWAP or DROPPED; next frame swaps immediately once RD_RESET_STATE=1.
- NEOPIX_BLANK_EN: RD_COUNT=6, no frames for 500 cycles, RD_RESET_STATE=1 -> RD_COUNT=0, RD_BANK unchanged, no FRAME_SWAP; without the macro RD_COUNT stays 6.
